// File: rtl/issueunit_ls_pkg.sv
// Shared types and constants for the load/store issue unit.
// Opcode encodings, FSM state encoding and an alignment helper.
package issueunit_ls_pkg;

  localparam logic ISSUELS_FUNC_LW = 1'b0;
  localparam logic ISSUELS_FUNC_SW = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } ls_state_e;

  function automatic logic is_misaligned(
    input logic [1:0] lsb
  );
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/issueunit_ls_fifo.sv
// lsresult_fifo: parameterised FIFO for load results awaiting the CDB.
// Ports: push/push_data in, pop in, pop_data (head, 0 when empty), count/full/empty out.
module lsresult_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 38
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

  // A grant on an empty buffer is dropped; a push into a full
  // buffer only lands if the head leaves on the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/issueunit_ls.sv
// Load/store issue unit: one data-memory access at a time, loads to CDB.
// Ports: issuels_* from LS queue, dmem_* to memory, lscdb_* to arbiter, status.
module issueunit_ls
  import issueunit_ls_pkg::*;
#(
  parameter int RESBUF_DEPTH = 2,
  parameter int TAG_W        = 6,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issuels_opcode,
  input  logic [TAG_W-1:0]  issuels_rttag,
  input  logic [DATA_W-1:0] issuels_addr,
  input  logic [DATA_W-1:0] issuels_data,
  input  logic              issuels_ready,
  output logic              issuels_done,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              lscdb_req,
  output logic [TAG_W-1:0]  lscdb_tag,
  output logic [DATA_W-1:0] lscdb_data,
  input  logic              lscdb_grant,
  output logic              ls_misalign,
  output logic              ls_busy
);

  localparam int ENT_W = TAG_W + DATA_W;
  localparam int CNT_W = $clog2(RESBUF_DEPTH) + 1;

  ls_state_e         state_q, state_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [TAG_W-1:0]  rttag_q, rttag_d;
  logic              misalign_q, misalign_d;

  logic              fifo_push;
  logic [ENT_W-1:0]  fifo_wdata;
  logic [ENT_W-1:0]  fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  logic              is_store;
  logic              misal;

  assign is_store = (issuels_opcode == ISSUELS_FUNC_SW);
  assign misal    = is_misaligned(issuels_addr[1:0]);

  // Loads only need a slot because the FSM is the sole pusher; gating
  // with reset keeps the accept strobe low while held in reset.
  assign issuels_done = reset
                      & (state_q == ST_IDLE)
                      & issuels_ready
                      & (is_store | ~fifo_full);

  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    rttag_d      = rttag_q;
    misalign_d   = misalign_q;
    fifo_push    = 1'b0;
    fifo_wdata   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (issuels_done) begin
          if (misal) begin
            // No access; a load still returns a zero so its
            // consumers wake up.
            misalign_d = 1'b1;
            if (!is_store) begin
              fifo_push  = 1'b1;
              fifo_wdata = {issuels_rttag, {DATA_W{1'b0}}};
            end
          end else begin
            state_d      = ST_MEM;
            dmem_req_d   = 1'b1;
            dmem_we_d    = is_store;
            dmem_addr_d  = issuels_addr;
            dmem_wdata_d = issuels_data;
            rttag_d      = issuels_rttag;
          end
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          state_d    = ST_IDLE;
          dmem_req_d = 1'b0;
          if (!dmem_we_q) begin
            fifo_push  = 1'b1;
            fifo_wdata = {rttag_q, dmem_rdata};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      rttag_q      <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      rttag_q      <= rttag_d;
      misalign_q   <= misalign_d;
    end
  end

  lsresult_fifo #(
    .DEPTH (RESBUF_DEPTH),
    .WIDTH (ENT_W)
  ) u_resbuf (
    .clk       (clk),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (lscdb_grant),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign lscdb_req   = ~fifo_empty;
  assign lscdb_tag   = fifo_head[ENT_W-1:DATA_W];
  assign lscdb_data  = fifo_head[DATA_W-1:0];
  assign ls_misalign = misalign_q;
  assign ls_busy     = (state_q != ST_IDLE) | (fifo_count != '0);

endmodule

// File: doc/issueunit_ls.md
Name: issueunit_ls

Overview:
- Load/store issue unit, directly downstream of the load/store issue queue.
- Accepts the oldest ready memory op from the queue and performs one data-memory access at a time, with a variable-latency req/ack handshake.
- Stores retire silently on memory ack.
- Load results enter a small result buffer and are broadcast on the CDB through a request/grant handshake with the CDB arbiter.

Parameters:
- RESBUF_DEPTH, 2, load-result buffer entries (power of two, >=2)
- TAG_W, 6, physical register tag width
- DATA_W, 32, data and address width

Ports:
- clk  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- issuels_opcode  in  1  `ISSUELS_FUNC_LW / `ISSUELS_FUNC_SW
- issuels_rttag  in  TAG_W  destination tag (loads)
- issuels_addr  in  DATA_W  effective byte address
- issuels_data  in  DATA_W  store data
- issuels_ready  in  1  queue head is valid and operands are resolved
- issuels_done  out  1  op accepted this cycle; queue pops its head
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  DATA_W  byte address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  request complete this cycle
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack
- lscdb_req  out  1  result buffer non-empty
- lscdb_tag  out  TAG_W  head entry tag
- lscdb_data  out  DATA_W  head entry data
- lscdb_grant  in  1  arbiter takes head this cycle
- ls_misalign  out  1  sticky: a misaligned address was seen
- ls_busy  out  1  FSM not in IDLE or buffer non-empty

Behaviour:
- Reset (reset=0, async):
  - FSM goes to IDLE and the result buffer empties.
  - All outputs are 0: issuels_done, dmem_req, dmem_we, dmem_addr, dmem_wdata, lscdb_req, lscdb_tag, lscdb_data, ls_misalign, ls_busy.
  - Reset mid-access drops dmem_req immediately. A late dmem_ack after reset is ignored (state is IDLE).
- FSM states: IDLE, MEM.
- issuels_done (combinational):
  - Asserted when state==IDLE, issuels_ready==1, and (opcode==SW or buffer count < RESBUF_DEPTH).
  - Never asserted in MEM.
  - It is a one-cycle accept. The queue removes its head on that same edge.
- IDLE to MEM on issuels_done:
  - opcode, rttag, addr and data are registered.
  - The next cycle asserts dmem_req with dmem_we = (opcode==SW) and address/data from the registers.
- Misaligned op (issuels_addr[1:0] != 0):
  - Still accepted (done pulses) and ls_misalign sets (sticky until reset).
  - No memory access: FSM stays IDLE.
  - A misaligned load pushes {rttag, 0} into the buffer so its consumers do not deadlock.
- MEM:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until dmem_ack.
  - On dmem_ack, go to IDLE and drop dmem_req the next cycle.
  - Load on ack: push {tag, dmem_rdata}. Space is guaranteed by the accept rule, since only this FSM pushes.
  - Store on ack: nothing is pushed.
- Minimum op latency: accept at cycle T, dmem_req from T+1, ack earliest T+1.
  - Next accept is possible at T+2.
  - Load data appears on lscdb_* at T+2 at the earliest.
- Result buffer: FIFO with read and write pointers of log2(RESBUF_DEPTH) bits plus a count.
  - Wrap-around is natural modulo.
  - lscdb_req = (count != 0); lscdb_tag/data show the head entry (0 when empty).
  - Pop on lscdb_req & lscdb_grant. Push and pop in the same cycle leave count unchanged.
  - A grant while empty is ignored.
- Buffer full: load accept is stalled (issuels_done=0); a store may still be accepted.
- Ordering:
  - Memory ops issue strictly in queue order, one outstanding.
  - CDB broadcasts follow load order.

Decomposition:
- `ISSUELS_FUNC_LW=1'b0 and `ISSUELS_FUNC_SW=1'b1, plus the FSM state encodings, go in globals.vh.
- One sub-module: lsresult_fifo (parameterised depth/width FIFO, push/pop/count/full/empty), instantiated for the result buffer.

Test Plan:
- Load at addr 0x100, tag 0x05; dmem_ack 3 cycles after dmem_req with rdata 0xDEADBEEF; grant held 1 -> issuels_done 1 cycle; dmem_req=1, we=0 for 3 cycles; lscdb_req with tag 0x05, data 0xDEADBEEF one cycle after ack; popped on grant.
- Store addr 0x20, data 0x12345678, ack after 1 cycle -> dmem_we=1, wdata=0x12345678; no lscdb_req; back-to-back store accepted 2 cycles after the first accept.
- grant=0; three loads tags 1,2,3 ready -> two accepted and buffered; third done withheld; store behind it not reached (FIFO order); raise grant -> tag1 then tag2 broadcast, then tag3 accepted.
- Simultaneous push and pop with count=1 -> count stays 1, order tag2 then tag3 preserved across pointer wrap.
- Load at addr 0x102, tag 0x09 -> done pulses, no dmem_req, ls_misalign=1 sticky, CDB broadcast tag 0x09 data 0.
- reset=0 asserted while in MEM with dmem_req=1 -> dmem_req and lscdb_req drop asynchronously; ack arriving after release of reset is ignored; buffer empty.
